// File: rtl/btn_irq_ctrl_pkg.sv
// btn_irq_ctrl_pkg: shared constants and priority encoder for the button interrupt front end
package btn_irq_ctrl_pkg;
  localparam int NUM_IRQ_DEF = 3;
  localparam int MAX_IRQ = 4;
  localparam int ID_W = 2;
  function automatic logic [ID_W-1:0] prio_enc(input logic [MAX_IRQ-1:0] v);
    prio_enc = '0;
    for (int i = 0; i < MAX_IRQ; i++) if (v[i]) prio_enc = ID_W'(i);
  endfunction
endpackage

// File: rtl/btn_irq_ctrl_if.sv
// btn_irq_ctrl_if: button/CPU-side signals of the interrupt front end
// master drives btn, irq_en, irq_clr; slave (the controller) drives irq_req, irq_id, IRW
interface btn_irq_ctrl_if
  import btn_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF
);
  logic [NUM_IRQ-1:0] btn;
  logic [NUM_IRQ-1:0] irq_en;
  logic [NUM_IRQ-1:0] irq_clr;
  logic [NUM_IRQ-1:0] IRW;
  logic irq_req;
  logic [ID_W-1:0] irq_id;
  modport master (output btn, irq_en, irq_clr, input irq_req, irq_id, IRW);
  modport slave (input btn, irq_en, irq_clr, output irq_req, irq_id, IRW);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus counter debounce for one button
// ports: clk, rst (async active-low), i_btn raw level, o_db_rise one-cycle pulse after the accepted level rises
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_db_rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic r_s1, r_s2, r_db, r_rise;
  logic [CW-1:0] r_cnt;
  logic w_diff, w_flip;
  assign w_diff = r_s2 != r_db;
  // accept the new level on the DEBOUNCE_CYCLES-th consecutive disagreeing sample
  assign w_flip = w_diff && r_cnt == LAST;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_db <= 1'b0;
      r_cnt <= '0;
      r_rise <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      r_cnt <= w_diff && !w_flip ? r_cnt + 1'b1 : '0;
      if (w_flip) r_db <= r_s2;
      r_rise <= w_flip && r_s2;
    end
  assign o_db_rise = r_rise;
endmodule

// File: rtl/btn_irq_ctrl.sv
// btn_irq_ctrl: debounced, latched, prioritised button interrupts for the CPU
// ports: clk, rst (async active-low), bus (slave): btn/irq_en/irq_clr in, irq_req/irq_id/IRW out
module btn_irq_ctrl
  import btn_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  btn_irq_ctrl_if.slave bus
);
  logic [NUM_IRQ-1:0] w_rise, w_act, r_pend;
  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_ch
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .rst(rst),
      .i_btn(bus.btn[g]),
      .o_db_rise(w_rise[g])
    );
  end
  // a set event beats a simultaneous clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_pend <= '0;
    else r_pend <= w_rise | (r_pend & ~bus.irq_clr);
  assign w_act = r_pend & bus.irq_en;
  assign bus.IRW = r_pend;
  assign bus.irq_req = |w_act;
  assign bus.irq_id = prio_enc(MAX_IRQ'(w_act));
endmodule
